// File: rtl/bram_port_arbiter_if.sv
// Client and bram-side signal bundle for bram_port_arbiter.
// The arbiter takes the slave modport; clients/bram model take the master modport.
interface bram_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [1:0]    wr_req;
  logic [AW-1:0] wr_addr0;
  logic [AW-1:0] wr_addr1;
  logic [DW-1:0] wr_data0;
  logic [DW-1:0] wr_data1;
  logic [1:0]    wr_gnt;

  logic [1:0]    rd_req;
  logic [AW-1:0] rd_addr0;
  logic [AW-1:0] rd_addr1;
  logic [1:0]    rd_gnt;
  logic [1:0]    rd_valid;
  logic [DW-1:0] rd_data;

  logic          bram_wr_en;
  logic [AW-1:0] bram_addr_in;
  logic [DW-1:0] bram_data_in;
  logic          bram_rd_en;
  logic [AW-1:0] bram_addr_out;
  logic [DW-1:0] bram_data_out;

  modport slave (
    input  wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
    input  rd_req, rd_addr0, rd_addr1,
    input  bram_data_out,
    output wr_gnt, rd_gnt, rd_valid, rd_data,
    output bram_wr_en, bram_addr_in, bram_data_in, bram_rd_en, bram_addr_out
  );

  modport master (
    output wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
    output rd_req, rd_addr0, rd_addr1,
    output bram_data_out,
    input  wr_gnt, rd_gnt, rd_valid, rd_data,
    input  bram_wr_en, bram_addr_in, bram_data_in, bram_rd_en, bram_addr_out
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter for the write and read ports of a dual-port bram.
// Optional read-after-write forwarding on same-address collisions: BRAM_ARB_WR_FWD_EN.
module bram_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  bram_port_arbiter_if.slave  bus
);

  logic          wr_ptr;
  logic          rd_ptr;
  logic          rd_vld;
  logic          rd_owner;
  logic [1:0]    wr_gnt_c;
  logic [1:0]    rd_gnt_c;
  logic [AW-1:0] wr_addr_sel;
  logic [AW-1:0] rd_addr_sel;
  logic [DW-1:0] wr_data_sel;
  logic [DW-1:0] data_hold;
  logic [DW-1:0] rd_data_c;

  // ptr holds the last granted index; on contention the other requester wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
    case (req)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return ptr ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  always_comb begin
    wr_gnt_c = '0;
    rd_gnt_c = '0;
    if (rst_n) begin
      wr_gnt_c = rr_pick(bus.wr_req, wr_ptr);
      rd_gnt_c = rr_pick(bus.rd_req, rd_ptr);
    end
  end

  assign wr_addr_sel = wr_gnt_c[1] ? bus.wr_addr1 : bus.wr_addr0;
  assign wr_data_sel = wr_gnt_c[1] ? bus.wr_data1 : bus.wr_data0;
  assign rd_addr_sel = rd_gnt_c[1] ? bus.rd_addr1 : bus.rd_addr0;

  assign bus.wr_gnt        = wr_gnt_c;
  assign bus.rd_gnt        = rd_gnt_c;
  assign bus.bram_wr_en    = |wr_gnt_c;
  assign bus.bram_rd_en    = |rd_gnt_c;
  assign bus.bram_addr_in  = wr_addr_sel;
  assign bus.bram_data_in  = wr_data_sel;
  assign bus.bram_addr_out = rd_addr_sel;
  assign bus.rd_valid      = rd_vld ? (rd_owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rd_data       = rd_data_c;

`ifdef BRAM_ARB_WR_FWD_EN
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else begin
      fwd_hit  <= (|wr_gnt_c) && (|rd_gnt_c) && (wr_addr_sel == rd_addr_sel);
      fwd_data <= wr_data_sel;
    end
  end

  always_comb begin
    rd_data_c = data_hold;
    if (rd_vld) rd_data_c = fwd_hit ? fwd_data : bus.bram_data_out;
  end
`else
  always_comb begin
    rd_data_c = data_hold;
    if (rd_vld) rd_data_c = bus.bram_data_out;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= 1'b1;
      rd_ptr    <= 1'b1;
      rd_vld    <= 1'b0;
      rd_owner  <= 1'b0;
      data_hold <= '0;
    end else begin
      if (|wr_gnt_c) wr_ptr <= wr_gnt_c[1];
      if (|rd_gnt_c) begin
        rd_ptr   <= rd_gnt_c[1];
        rd_owner <= rd_gnt_c[1];
      end
      rd_vld <= |rd_gnt_c;
      // rd_data keeps the last returned word between valid pulses.
      if (rd_vld) data_hold <= rd_data_c;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed testbench for bram_port_arbiter with a read-before-write bram model.
module tb_bram_port_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [7:0] mem [256];

  bram_port_arbiter_if #(.AW(8), .DW(8)) bus ();

  bram_port_arbiter #(.AW(8), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle registered read, read-before-write on the same address.
  always @(posedge clk) begin
    if (bus.bram_rd_en) bus.bram_data_out <= mem[bus.bram_addr_out];
    if (bus.bram_wr_en) mem[bus.bram_addr_in] <= bus.bram_data_in;
  end

  task automatic idle();
    bus.wr_req = 2'b00;
    bus.rd_req = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single-requester write; grant is immediate when uncontended.
  task automatic do_write(input int r, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    idle();
    if (r == 0) begin
      bus.wr_addr0 = a; bus.wr_data0 = d; bus.wr_req = 2'b01;
    end else begin
      bus.wr_addr1 = a; bus.wr_data1 = d; bus.wr_req = 2'b10;
    end
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.wr_req = 2'b11; bus.rd_req = 2'b11;
    bus.wr_addr0 = 8'hFF; bus.wr_addr1 = 8'hFE;
    bus.wr_data0 = 8'h00; bus.wr_data1 = 8'h00;
    bus.rd_addr0 = 8'hFF; bus.rd_addr1 = 8'hFE;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.wr_gnt !== 2'b00) begin failures++; $display("FAIL rst_wr_gnt got=%b exp=00", bus.wr_gnt); end
    checks++; if (bus.rd_gnt !== 2'b00) begin failures++; $display("FAIL rst_rd_gnt got=%b exp=00", bus.rd_gnt); end
    checks++; if (bus.bram_wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%b exp=0", bus.bram_wr_en); end
    checks++; if (bus.bram_rd_en !== 1'b0) begin failures++; $display("FAIL rst_rd_en got=%b exp=0", bus.bram_rd_en); end
    checks++; if (bus.rd_valid !== 2'b00) begin failures++; $display("FAIL rst_rd_valid got=%b exp=00", bus.rd_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.wr_gnt !== 2'b01) begin failures++; $display("FAIL rst_first_wr_gnt got=%b exp=01", bus.wr_gnt); end
    checks++; if (bus.rd_gnt !== 2'b01) begin failures++; $display("FAIL rst_first_rd_gnt got=%b exp=01", bus.rd_gnt); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_single_write_read();
    @(negedge clk);
    idle();
    bus.wr_req = 2'b01; bus.wr_addr0 = 8'h23; bus.wr_data0 = 8'hA5;
    #1;
    checks++; if (bus.wr_gnt !== 2'b01) begin failures++; $display("FAIL swr_wr_gnt got=%b exp=01", bus.wr_gnt); end
    checks++; if (bus.bram_wr_en !== 1'b1 || bus.bram_addr_in !== 8'h23 || bus.bram_data_in !== 8'hA5) begin
      failures++; $display("FAIL swr_bram_wr got=%b/%h/%h exp=1/23/a5", bus.bram_wr_en, bus.bram_addr_in, bus.bram_data_in);
    end
    @(negedge clk);
    bus.wr_req = 2'b00;
    bus.rd_req = 2'b01; bus.rd_addr0 = 8'h23;
    #1;
    checks++; if (bus.rd_gnt !== 2'b01 || bus.bram_addr_out !== 8'h23) begin
      failures++; $display("FAIL swr_rd_gnt got=%b/%h exp=01/23", bus.rd_gnt, bus.bram_addr_out);
    end
    @(negedge clk);
    idle();
    checks++; if (bus.rd_valid !== 2'b01) begin failures++; $display("FAIL swr_rd_valid got=%b exp=01", bus.rd_valid); end
    checks++; if (bus.rd_data !== 8'hA5) begin failures++; $display("FAIL swr_rd_data got=%h exp=a5", bus.rd_data); end
    @(negedge clk);
    checks++; if (bus.rd_valid !== 2'b00) begin failures++; $display("FAIL swr_valid_drop got=%b exp=00", bus.rd_valid); end
  endtask

  task automatic test_contention();
    logic [1:0] exp, prev;
    do_reset();
    bus.wr_addr0 = 8'h80; bus.wr_data0 = 8'h01;
    bus.wr_addr1 = 8'h81; bus.wr_data1 = 8'h02;
    bus.rd_addr0 = 8'h80; bus.rd_addr1 = 8'h81;
    bus.wr_req = 2'b11; bus.rd_req = 2'b11;
    prev = 2'b00;
    for (int i = 0; i < 6; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++; if (bus.wr_gnt !== exp) begin failures++; $display("FAIL cont_wr_gnt[%0d] got=%b exp=%b", i, bus.wr_gnt, exp); end
      checks++; if (bus.rd_gnt !== exp) begin failures++; $display("FAIL cont_rd_gnt[%0d] got=%b exp=%b", i, bus.rd_gnt, exp); end
      if (i > 0) begin
        checks++; if (bus.rd_valid !== prev) begin failures++; $display("FAIL cont_rd_valid[%0d] got=%b exp=%b", i, bus.rd_valid, prev); end
      end
      prev = exp;
      @(negedge clk);
    end
    idle();
    checks++; if (bus.rd_valid !== 2'b10) begin failures++; $display("FAIL cont_last_valid got=%b exp=10", bus.rd_valid); end
  endtask

  task automatic test_concurrent();
    do_write(1, 8'h07, 8'h3C);
    @(negedge clk);
    bus.wr_req = 2'b01; bus.wr_addr0 = 8'h05; bus.wr_data0 = 8'h11;
    bus.rd_req = 2'b10; bus.rd_addr1 = 8'h07;
    #1;
    checks++; if (bus.wr_gnt !== 2'b01 || bus.rd_gnt !== 2'b10) begin
      failures++; $display("FAIL conc_gnts got=%b/%b exp=01/10", bus.wr_gnt, bus.rd_gnt);
    end
    @(negedge clk);
    idle();
    checks++; if (bus.rd_valid !== 2'b10 || bus.rd_data !== 8'h3C) begin
      failures++; $display("FAIL conc_rd got=%b/%h exp=10/3c", bus.rd_valid, bus.rd_data);
    end
    @(negedge clk);
    bus.rd_req = 2'b01; bus.rd_addr0 = 8'h05;
    @(negedge clk);
    idle();
    checks++; if (bus.rd_valid !== 2'b01 || bus.rd_data !== 8'h11) begin
      failures++; $display("FAIL conc_wr_back got=%b/%h exp=01/11", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_collision();
    logic [7:0] exp;
`ifdef BRAM_ARB_WR_FWD_EN
    exp = 8'h99;
`else
    exp = 8'h00;
`endif
    do_write(0, 8'h40, 8'h00);
    @(negedge clk);
    bus.wr_req = 2'b01; bus.wr_addr0 = 8'h40; bus.wr_data0 = 8'h99;
    bus.rd_req = 2'b01; bus.rd_addr0 = 8'h40;
    #1;
    checks++; if (bus.wr_gnt !== 2'b01 || bus.rd_gnt !== 2'b01) begin
      failures++; $display("FAIL coll_gnts got=%b/%b exp=01/01", bus.wr_gnt, bus.rd_gnt);
    end
    @(negedge clk);
    idle();
    checks++; if (bus.rd_valid !== 2'b01 || bus.rd_data !== exp) begin
      failures++; $display("FAIL coll_rd got=%b/%h exp=01/%h", bus.rd_valid, bus.rd_data, exp);
    end
    @(negedge clk);
    checks++; if (bus.rd_valid !== 2'b00 || bus.rd_data !== exp) begin
      failures++; $display("FAIL coll_hold got=%b/%h exp=00/%h", bus.rd_valid, bus.rd_data, exp);
    end
    bus.rd_req = 2'b10; bus.rd_addr1 = 8'h40;
    @(negedge clk);
    idle();
    checks++; if (bus.rd_valid !== 2'b10 || bus.rd_data !== 8'h99) begin
      failures++; $display("FAIL coll_later got=%b/%h exp=10/99", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_reset_mid_read();
    // Move both pointers to requester 0 so a restored reset value is observable.
    @(negedge clk);
    bus.wr_req = 2'b01; bus.wr_addr0 = 8'hF0; bus.wr_data0 = 8'h00;
    bus.rd_req = 2'b01; bus.rd_addr0 = 8'h05;
    @(negedge clk);
    idle();
    bus.rd_req = 2'b01; bus.rd_addr0 = 8'h05;
    #1;
    checks++; if (bus.rd_gnt !== 2'b01) begin failures++; $display("FAIL mid_rd_gnt got=%b exp=01", bus.rd_gnt); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rd_gnt !== 2'b00 || bus.bram_rd_en !== 1'b0) begin
      failures++; $display("FAIL mid_gnt_forced got=%b/%b exp=00/0", bus.rd_gnt, bus.bram_rd_en);
    end
    @(negedge clk);
    checks++; if (bus.rd_valid !== 2'b00) begin failures++; $display("FAIL mid_rd_valid got=%b exp=00", bus.rd_valid); end
    bus.wr_req = 2'b11; bus.rd_req = 2'b11;
    bus.wr_addr0 = 8'hF1; bus.wr_addr1 = 8'hF2;
    bus.rd_addr0 = 8'hF1; bus.rd_addr1 = 8'hF2;
    @(negedge clk);
    checks++; if (bus.rd_valid !== 2'b00) begin failures++; $display("FAIL mid_rd_valid2 got=%b exp=00", bus.rd_valid); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.wr_gnt !== 2'b01 || bus.rd_gnt !== 2'b01) begin
      failures++; $display("FAIL mid_ptr_reset got=%b/%b exp=01/01", bus.wr_gnt, bus.rd_gnt);
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.wr_req = 2'b00; bus.rd_req = 2'b00;
    bus.wr_addr0 = '0; bus.wr_addr1 = '0;
    bus.wr_data0 = '0; bus.wr_data1 = '0;
    bus.rd_addr0 = '0; bus.rd_addr1 = '0;
    test_reset();
    test_single_write_read();
    test_contention();
    test_concurrent();
    test_collision();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
